// File: rtl/ng_ctr_pkg.sv
// Shared types and constants for the counter-increment sequencer.
// The PINC/MINC addends are 16-bit ones-complement +1 and -1.
package ng_ctr_pkg;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      CALC,
      WRITE
   } ctr_state_t;

   localparam logic [15:0] PINC_ADDEND = 16'o000001;
   localparam logic [15:0] MINC_ADDEND = 16'o177776;
   localparam logic [15:0] CTR_ADDR_LO = 16'o34;
   localparam logic [15:0] CTR_ADDR_HI = 16'o40;

endpackage

// File: rtl/ng_oc_add16.sv
// Combinational 16-bit ones-complement adder with end-around carry.
// The carry re-add cannot ripple out again: the largest raw sum is 0x1FFFE.
module ng_oc_add16 (
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic [15:0] sum
);

   logic [16:0] raw;

   always_comb begin
      raw = {1'b0, a} + {1'b0, b};
      sum = raw[15:0] + {15'b0, raw[16]};
   end

endmodule

// File: rtl/ng_cinc_seq.sv
// Counter-increment sequencer: steals one erasable-memory cycle per serviced
// PINC/MINC request, updates the counter word and strobes WOVR_n.
module ng_cinc_seq
   import ng_ctr_pkg::*;
#(
   parameter int AW = 12,
   parameter int DW = 15
) (
   input  logic          CLK2,
   input  logic          GENRST,
   input  logic          INST_END,
   input  logic          SB01,
   input  logic          SB02,
   input  logic [15:0]   CTR_BUS,
   output logic          MEM_RD_REQ,
   output logic          MEM_WR_REQ,
   input  logic          MEM_ACK,
   output logic [AW-1:0] MEM_ADDR,
   input  logic [DW-1:0] MEM_RD_DATA,
   output logic [DW-1:0] MEM_WR_DATA,
   output logic [15:0]   WRITE_BUS,
   output logic          WOVR_n,
   output logic          BUSY,
   output logic          CTR_DONE,
   output logic          SB_ERR
);

   ctr_state_t    state, state_nxt;
   logic          pinc_q;
   logic [DW-1:0] rd_word;
   logic [15:0]   word_ext;
   logic [15:0]   addend;
   logic [15:0]   sum;
   logic          take_req;
   logic          unused_ctr_hi;

   assign unused_ctr_hi = ^CTR_BUS[15:AW];
   assign take_req      = INST_END & (SB01 ^ SB02);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (take_req) state_nxt = READ;
         READ:    if (MEM_ACK)  state_nxt = CALC;
         CALC:                  state_nxt = WRITE;
         WRITE:   if (MEM_ACK)  state_nxt = IDLE;
         default:               state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK2 or negedge GENRST) begin
      if (!GENRST) state <= IDLE;
      else         state <= state_nxt;
   end

   // Request/busy flags are registered from the next state so they line up
   // with the state register; WOVR_n is low only on entry to WRITE.
   always_ff @(posedge CLK2 or negedge GENRST) begin
      if (!GENRST) begin
         MEM_RD_REQ <= 1'b0;
         MEM_WR_REQ <= 1'b0;
         BUSY       <= 1'b0;
         WOVR_n     <= 1'b1;
      end else begin
         MEM_RD_REQ <= (state_nxt == READ);
         MEM_WR_REQ <= (state_nxt == WRITE);
         BUSY       <= (state_nxt != IDLE);
         WOVR_n     <= !(state == CALC);
      end
   end

   // Completion must coincide with the accepting MEM_ACK cycle, so it is
   // decoded from the registered state and the acknowledge.
   assign CTR_DONE = (state == WRITE) & MEM_ACK;

   always_comb begin
      word_ext = {{(17 - DW){rd_word[DW-1]}}, rd_word[DW-2:0]};
      addend   = pinc_q ? PINC_ADDEND : MINC_ADDEND;
   end

   ng_oc_add16 u_add (
      .a   (word_ext),
      .b   (addend),
      .sum (sum)
   );

   always_ff @(posedge CLK2 or negedge GENRST) begin
      if (!GENRST) begin
         pinc_q      <= 1'b0;
         rd_word     <= '0;
         MEM_ADDR    <= '0;
         MEM_WR_DATA <= '0;
         WRITE_BUS   <= '0;
         SB_ERR      <= 1'b0;
      end else begin
         if (state == IDLE && INST_END && SB01 && SB02) SB_ERR <= 1'b1;
         if (state == IDLE && take_req) begin
            pinc_q   <= SB01;
            MEM_ADDR <= CTR_BUS[AW-1:0];
         end
         if (state == READ && MEM_ACK) rd_word <= MEM_RD_DATA;
         if (state == CALC) begin
            WRITE_BUS   <= sum;
            MEM_WR_DATA <= {sum[15], sum[DW-2:0]};
         end
      end
   end

endmodule

// File: tb/tb_ng_cinc_seq.sv
// Directed self-checking bench for ng_cinc_seq with hand-computed results.
module tb_ng_cinc_seq;
   import ng_ctr_pkg::*;

   logic        CLK2 = 1'b0;
   logic        GENRST;
   logic        INST_END;
   logic        SB01;
   logic        SB02;
   logic [15:0] CTR_BUS;
   logic        MEM_RD_REQ;
   logic        MEM_WR_REQ;
   logic        MEM_ACK;
   logic [11:0] MEM_ADDR;
   logic [14:0] MEM_RD_DATA;
   logic [14:0] MEM_WR_DATA;
   logic [15:0] WRITE_BUS;
   logic        WOVR_n;
   logic        BUSY;
   logic        CTR_DONE;
   logic        SB_ERR;

   int checks = 0;
   int errors = 0;

   always #5 CLK2 = ~CLK2;

   ng_cinc_seq #(.AW(12), .DW(15)) dut (
      .CLK2        (CLK2),
      .GENRST      (GENRST),
      .INST_END    (INST_END),
      .SB01        (SB01),
      .SB02        (SB02),
      .CTR_BUS     (CTR_BUS),
      .MEM_RD_REQ  (MEM_RD_REQ),
      .MEM_WR_REQ  (MEM_WR_REQ),
      .MEM_ACK     (MEM_ACK),
      .MEM_ADDR    (MEM_ADDR),
      .MEM_RD_DATA (MEM_RD_DATA),
      .MEM_WR_DATA (MEM_WR_DATA),
      .WRITE_BUS   (WRITE_BUS),
      .WOVR_n      (WOVR_n),
      .BUSY        (BUSY),
      .CTR_DONE    (CTR_DONE),
      .SB_ERR      (SB_ERR)
   );

   task automatic test_reset();
      GENRST = 1'b0; INST_END = 1'b0; SB01 = 1'b0; SB02 = 1'b0;
      CTR_BUS = '0; MEM_ACK = 1'b0; MEM_RD_DATA = '0;
      repeat (3) @(posedge CLK2);
      @(negedge CLK2);
      checks++;
      if ({MEM_RD_REQ, MEM_WR_REQ, BUSY, CTR_DONE, SB_ERR, WOVR_n} !== 6'b000001 ||
          MEM_ADDR !== 12'd0 || MEM_WR_DATA !== 15'd0 || WRITE_BUS !== 16'd0) begin
         errors++;
         $display("FAIL reset_values: got rd=%b wr=%b busy=%b done=%b err=%b wovr_n=%b addr=%o wd=%o bus=%o, expected all zero with wovr_n=1",
                  MEM_RD_REQ, MEM_WR_REQ, BUSY, CTR_DONE, SB_ERR, WOVR_n, MEM_ADDR, MEM_WR_DATA, WRITE_BUS);
      end
      GENRST = 1'b1;
      @(posedge CLK2); #1;
   endtask

   // One serviced request. Cycle 0 is the INST_END cycle; memory ACK is
   // given after rd_wait / wr_wait request cycles without acknowledge.
   task automatic run_op(input string name, input logic pinc, input logic [15:0] addr,
                         input logic [14:0] word, input int rd_wait, input int wr_wait,
                         input logic [14:0] exp_mem, input logic [15:0] exp_bus,
                         input logic coincide);
      int cyc = 1;
      int rd_seen = 0;
      int wr_seen = 0;
      int busy_n = 0;
      int wovr_cnt = 0;
      int wovr_cyc = -1;
      int done_cyc = -1;
      int exp_total = 3 + rd_wait + wr_wait;
      logic addr_ok = 1'b1;
      INST_END = 1'b1; SB01 = pinc; SB02 = !pinc; CTR_BUS = addr;
      @(posedge CLK2); #1;
      INST_END = 1'b0; SB01 = 1'b0; SB02 = 1'b0;
      while (cyc < 40 && done_cyc < 0) begin
         MEM_ACK = 1'b0;
         if (MEM_RD_REQ) begin
            if (MEM_ADDR !== addr[11:0]) addr_ok = 1'b0;
            if (rd_seen == rd_wait) begin MEM_ACK = 1'b1; MEM_RD_DATA = word; end
            rd_seen++;
         end
         if (MEM_WR_REQ) begin
            if (wr_seen == wr_wait) begin
               MEM_ACK = 1'b1;
               if (coincide) begin INST_END = 1'b1; SB01 = 1'b1; end
            end
            wr_seen++;
         end
         @(negedge CLK2);
         if (BUSY) busy_n++;
         if (!WOVR_n) begin wovr_cnt++; if (wovr_cyc < 0) wovr_cyc = cyc; end
         if (CTR_DONE) begin
            done_cyc = cyc;
            checks++;
            if (MEM_WR_DATA !== exp_mem) begin
               errors++;
               $display("FAIL %s mem_wr_data: got %o expected %o", name, MEM_WR_DATA, exp_mem);
            end
            checks++;
            if (WRITE_BUS !== exp_bus) begin
               errors++;
               $display("FAIL %s write_bus: got %o expected %o", name, WRITE_BUS, exp_bus);
            end
         end
         @(posedge CLK2); #1;
         cyc++;
      end
      MEM_ACK = 1'b0; INST_END = 1'b0; SB01 = 1'b0;
      checks++;
      if (done_cyc != exp_total) begin
         errors++;
         $display("FAIL %s done_cycle: got %0d expected %0d", name, done_cyc, exp_total);
      end
      checks++;
      if (busy_n != exp_total) begin
         errors++;
         $display("FAIL %s busy_cycles: got %0d expected %0d", name, busy_n, exp_total);
      end
      checks++;
      if (wovr_cnt != 1 || wovr_cyc != 3 + rd_wait) begin
         errors++;
         $display("FAIL %s wovr_n: low %0d cycles first at %0d, expected 1 cycle at %0d",
                  name, wovr_cnt, wovr_cyc, 3 + rd_wait);
      end
      checks++;
      if (!addr_ok) begin
         errors++;
         $display("FAIL %s mem_addr: got %o expected %o", name, MEM_ADDR, addr[11:0]);
      end
      @(negedge CLK2);
      checks++;
      if (BUSY !== 1'b0 || MEM_RD_REQ !== 1'b0 || WOVR_n !== 1'b1) begin
         errors++;
         $display("FAIL %s idle_after: got busy=%b rd=%b wovr_n=%b expected 0 0 1",
                  name, BUSY, MEM_RD_REQ, WOVR_n);
      end
      @(posedge CLK2); #1;
   endtask

   task automatic test_increments();
      run_op("pinc_5", 1'b1, CTR_ADDR_LO + 16'd2, 15'o00005, 0, 0, 15'o00006, 16'o000006, 1'b0);
      run_op("pinc_ovf", 1'b1, CTR_ADDR_LO + 16'd3, 15'o37777, 0, 0, 15'o00000, 16'o040000, 1'b0);
      run_op("minc_ovf", 1'b0, CTR_ADDR_HI, 15'o40000, 0, 0, 15'o77777, 16'o137777, 1'b0);
      run_op("minc_zero", 1'b0, CTR_ADDR_LO + 16'd1, 15'o00000, 1, 0, 15'o77776, 16'o177776, 1'b0);
   endtask

   task automatic test_neg_zero_slow();
      run_op("pinc_negzero_slow", 1'b1, CTR_ADDR_LO, 15'o77777, 2, 3, 15'o00001, 16'o000001, 1'b0);
   endtask

   task automatic test_no_request();
      int busy_seen = 0;
      INST_END = 1'b1; SB01 = 1'b0; SB02 = 1'b0; CTR_BUS = CTR_ADDR_LO;
      @(posedge CLK2); #1;
      INST_END = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK2);
         if (BUSY || MEM_RD_REQ) busy_seen++;
         @(posedge CLK2); #1;
      end
      checks++;
      if (busy_seen != 0 || SB_ERR !== 1'b0) begin
         errors++;
         $display("FAIL no_request: busy/req cycles %0d sb_err=%b, expected 0 and 0", busy_seen, SB_ERR);
      end
   endtask

   task automatic test_sb_error();
      int busy_seen = 0;
      INST_END = 1'b1; SB01 = 1'b1; SB02 = 1'b1; CTR_BUS = CTR_ADDR_LO;
      @(posedge CLK2); #1;
      INST_END = 1'b0; SB01 = 1'b0; SB02 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK2);
         if (BUSY || MEM_RD_REQ) busy_seen++;
         @(posedge CLK2); #1;
      end
      checks++;
      if (busy_seen != 0) begin
         errors++;
         $display("FAIL sb_err_no_cycle: busy/req cycles %0d expected 0", busy_seen);
      end
      checks++;
      if (SB_ERR !== 1'b1) begin
         errors++;
         $display("FAIL sb_err_set: got %b expected 1", SB_ERR);
      end
      run_op("after_err", 1'b1, CTR_ADDR_LO + 16'd2, 15'o00010, 0, 0, 15'o00011, 16'o000011, 1'b0);
      checks++;
      if (SB_ERR !== 1'b1) begin
         errors++;
         $display("FAIL sb_err_sticky: got %b expected 1", SB_ERR);
      end
   endtask

   task automatic test_back_to_back();
      run_op("coincide", 1'b0, CTR_ADDR_LO + 16'd4, 15'o00003, 0, 1, 15'o00002, 16'o000002, 1'b1);
      run_op("next_boundary", 1'b1, CTR_ADDR_LO + 16'd4, 15'o00002, 0, 0, 15'o00003, 16'o000003, 1'b0);
   endtask

   task automatic test_reset_mid();
      int guard = 0;
      INST_END = 1'b1; SB01 = 1'b1; SB02 = 1'b0; CTR_BUS = CTR_ADDR_LO + 16'd2;
      @(posedge CLK2); #1;
      INST_END = 1'b0; SB01 = 1'b0;
      while (!MEM_WR_REQ && guard < 20) begin
         MEM_ACK = MEM_RD_REQ;
         MEM_RD_DATA = 15'o00100;
         @(posedge CLK2); #1;
         guard++;
      end
      MEM_ACK = 1'b0;
      checks++;
      if (!MEM_WR_REQ) begin
         errors++;
         $display("FAIL rst_mid_reach_write: mem_wr_req %b expected 1", MEM_WR_REQ);
      end
      #2 GENRST = 1'b0;
      #1;
      checks++;
      if ({MEM_RD_REQ, MEM_WR_REQ, BUSY, CTR_DONE, SB_ERR, WOVR_n} !== 6'b000001 ||
          MEM_ADDR !== 12'd0 || MEM_WR_DATA !== 15'd0 || WRITE_BUS !== 16'd0) begin
         errors++;
         $display("FAIL rst_mid_values: got rd=%b wr=%b busy=%b done=%b err=%b wovr_n=%b addr=%o wd=%o bus=%o, expected reset values",
                  MEM_RD_REQ, MEM_WR_REQ, BUSY, CTR_DONE, SB_ERR, WOVR_n, MEM_ADDR, MEM_WR_DATA, WRITE_BUS);
      end
      @(posedge CLK2); #3;
      GENRST = 1'b1;
      @(posedge CLK2); #1;
      run_op("after_rst", 1'b1, CTR_ADDR_LO + 16'd2, 15'o00006, 0, 0, 15'o00007, 16'o000007, 1'b0);
   endtask

   initial begin
      test_reset();
      test_increments();
      test_neg_zero_slow();
      test_no_request();
      test_sb_error();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
